// File: rtl/dwt_lift53_1d_pkg.sv
// Shared definitions for the LeGall 5/3 lifting stage.
// Contents: default sample/coefficient widths, the lifting FSM state
// encoding and the sample/coefficient typedefs used by the stage and its bench.
package dwt_lift53_1d_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int COEF_W_DEF = DATA_W_DEF + 2;

    // S_E0: expecting first even sample of a row
    // S_ODD: expecting an odd sample
    // S_EVEN: expecting the next even sample (completes a pair)
    // S_TAIL: row ended on an odd sample, emit the mirrored last pair
    typedef enum logic [1:0] {
        S_E0   = 2'd0,
        S_ODD  = 2'd1,
        S_EVEN = 2'd2,
        S_TAIL = 2'd3
    } lift_state_t;

    typedef logic signed [DATA_W_DEF-1:0] sample_t;
    typedef logic signed [COEF_W_DEF-1:0] coef_t;

endpackage

// File: rtl/dwt_lift53_1d_if.sv
// Stream bundle for the 5/3 lifting stage.
// Input side : in_valid, in_ready, in_data, in_last
// Output side: out_valid, out_ready, out_s, out_d, out_last, err_odd
// master drives samples and out_ready; slave is the lifting stage.
interface dwt_lift53_1d_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = DATA_W + 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [COEF_W-1:0] out_s;
    logic signed [COEF_W-1:0] out_d;
    logic                     out_last;
    logic                     err_odd;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_s, out_d, out_last, err_odd
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_s, out_d, out_last, err_odd
    );
endinterface

// File: rtl/dwt_lift53_1d_kernel.sv
// Combinational 5/3 lifting kernel: one predict and one update step.
// Inputs : x_even = x[2n], x_odd = x[2n+1], x_next = x[2n+2] (or mirrored
//          x[2n] at the row end), d_prev = d[n-1], use_self = take d[n] as d[n-1]
//          (left-edge mirror).
// Outputs: d = detail d[n], s = approximation s[n].
module lift53_kernel #(
    parameter int DATA_W = 16,
    parameter int COEF_W = DATA_W + 2
) (
    input  logic signed [DATA_W-1:0] x_even,
    input  logic signed [DATA_W-1:0] x_odd,
    input  logic signed [DATA_W-1:0] x_next,
    input  logic signed [COEF_W-1:0] d_prev,
    input  logic                     use_self,
    output logic signed [COEF_W-1:0] d,
    output logic signed [COEF_W-1:0] s
);
    // One extra bit so the intermediate sums never wrap before the shifts.
    localparam int W = COEF_W + 1;
    localparam logic signed [W-1:0] ROUND = W'(3'sd2);

    logic signed [W-1:0] xe_s;
    logic signed [W-1:0] xo_s;
    logic signed [W-1:0] xn_s;
    logic signed [W-1:0] d_w_s;
    logic signed [W-1:0] dp_w_s;
    logic signed [W-1:0] s_w_s;

    // Predict then update; >>> on signed operands gives floor division.
    always_comb begin
        xe_s  = W'(x_even);
        xo_s  = W'(x_odd);
        xn_s  = W'(x_next);
        d_w_s = xo_s - ((xe_s + xn_s) >>> 1);
        if (use_self) begin
            dp_w_s = d_w_s;
        end else begin
            dp_w_s = W'(d_prev);
        end
        s_w_s = xe_s + ((dp_w_s + d_w_s + ROUND) >>> 2);
    end

    assign d = COEF_W'(d_w_s);
    assign s = COEF_W'(s_w_s);

endmodule

// File: rtl/dwt_lift53_1d.sv
// One-level streaming 1D LeGall 5/3 lifting stage.
// Ports: clk, rst (async, active-high), bus (slave side of dwt_lift53_1d_if):
//   in_valid/in_ready/in_data/in_last  sample stream, one sample per transfer
//   out_valid/out_ready/out_s/out_d/out_last  one (s,d) pair per two samples
//   err_odd  one-cycle pulse when a row had odd length
// Symmetric extension at both ends; the output is a single register stage.
module dwt_lift53_1d
    import dwt_lift53_1d_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int COEF_W = DATA_W + 2
) (
    input  logic            clk,
    input  logic            rst,
    dwt_lift53_1d_if.slave  bus
);
    lift_state_t              state_r;
    logic signed [DATA_W-1:0] e_prev_r;
    logic signed [DATA_W-1:0] o_prev_r;
    logic signed [COEF_W-1:0] d_prev_r;
    logic                     first_r;
    logic                     out_valid_r;
    logic signed [COEF_W-1:0] out_s_r;
    logic signed [COEF_W-1:0] out_d_r;
    logic                     out_last_r;
    logic                     err_odd_r;

    logic                     out_free_s;
    logic                     in_ready_s;
    logic                     in_fire_s;
    logic                     tail_s;
    logic signed [DATA_W-1:0] x_next_s;
    logic signed [COEF_W-1:0] k_d_s;
    logic signed [COEF_W-1:0] k_s_s;

    // The output register can take a new pair when empty or draining this cycle.
    assign out_free_s = !out_valid_r || bus.out_ready;
    assign in_ready_s = (state_r != S_TAIL) && out_free_s;
    assign in_fire_s  = bus.in_valid && in_ready_s;
    assign tail_s     = (state_r == S_TAIL);

    // At the row end the missing x[2N] mirrors to x[2N-2], held in e_prev.
    always_comb begin
        if (tail_s) begin
            x_next_s = e_prev_r;
        end else begin
            x_next_s = bus.in_data;
        end
    end

    lift53_kernel #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W)
    ) u_kernel (
        .x_even   (e_prev_r),
        .x_odd    (o_prev_r),
        .x_next   (x_next_s),
        .d_prev   (d_prev_r),
        .use_self (first_r),
        .d        (k_d_s),
        .s        (k_s_s)
    );

    // Lifting FSM together with the registered output pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_E0;
            e_prev_r    <= '0;
            o_prev_r    <= '0;
            d_prev_r    <= '0;
            first_r     <= 1'b1;
            out_valid_r <= 1'b0;
            out_s_r     <= '0;
            out_d_r     <= '0;
            out_last_r  <= 1'b0;
            err_odd_r   <= 1'b0;
        end else begin
            err_odd_r <= 1'b0;
            if (out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
            case (state_r)
                S_E0: begin
                    if (in_fire_s) begin
                        e_prev_r <= bus.in_data;
                        if (bus.in_last) begin
                            err_odd_r <= 1'b1;
                        end else begin
                            state_r <= S_ODD;
                        end
                    end
                end
                S_ODD: begin
                    if (in_fire_s) begin
                        o_prev_r <= bus.in_data;
                        state_r  <= bus.in_last ? S_TAIL : S_EVEN;
                    end
                end
                S_EVEN: begin
                    if (in_fire_s) begin
                        out_valid_r <= 1'b1;
                        out_s_r     <= k_s_s;
                        out_d_r     <= k_d_s;
                        if (bus.in_last) begin
                            // Odd-length row: trailing even sample is dropped.
                            out_last_r <= 1'b1;
                            err_odd_r  <= 1'b1;
                            first_r    <= 1'b1;
                            state_r    <= S_E0;
                        end else begin
                            out_last_r <= 1'b0;
                            e_prev_r   <= bus.in_data;
                            d_prev_r   <= k_d_s;
                            first_r    <= 1'b0;
                            state_r    <= S_ODD;
                        end
                    end
                end
                S_TAIL: begin
                    if (out_free_s) begin
                        out_valid_r <= 1'b1;
                        out_s_r     <= k_s_s;
                        out_d_r     <= k_d_s;
                        out_last_r  <= 1'b1;
                        first_r     <= 1'b1;
                        state_r     <= S_E0;
                    end
                end
                default: begin
                    state_r <= S_E0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_s     = out_s_r;
    assign bus.out_d     = out_d_r;
    assign bus.out_last  = out_last_r;
    assign bus.err_odd   = err_odd_r;

endmodule

// File: tb/tb_dwt_lift53_1d.sv
// Directed bench for dwt_lift53_1d: table of rows with hand-computed
// (s,d,last) pairs and odd-length flags, plus backpressure and reset sequences.
module tb_dwt_lift53_1d;
    import dwt_lift53_1d_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dwt_lift53_1d_if bus ();

    dwt_lift53_1d dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0]       len;
        logic [5:0][15:0] x;
        logic [1:0]       np;
        logic [2:0][17:0] es;
        logic [2:0][17:0] ed;
        logic [2:0]       el;
        logic             err;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    int errors = 0;
    int checks = 0;
    coef_t cap_s [$];
    coef_t cap_d [$];
    int    cap_l [$];
    int    err_cnt = 0;

    // Capture every output transfer and every err_odd cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                cap_s.push_back(bus.out_s);
                cap_d.push_back(bus.out_d);
                cap_l.push_back(int'(bus.out_last));
            end
            if (bus.err_odd) err_cnt++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input int data, input bit last);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = data[15:0];
        bus.in_last  = last;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                done = 1'b1;
                break;
            end
        end
        check("in_ready_wait", int'(done), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic clear_cap();
        cap_s.delete();
        cap_d.delete();
        cap_l.delete();
        err_cnt = 0;
    endtask

    task automatic compare_row(input int idx, input string tag);
        int n;
        n = int'(vecs[idx].np);
        check({tag, "_npairs"}, cap_s.size(), n);
        for (int p = 0; p < n && p < cap_s.size(); p++) begin
            check({tag, "_s"}, int'(cap_s[p]), int'($signed(vecs[idx].es[p])));
            check({tag, "_d"}, int'(cap_d[p]), int'($signed(vecs[idx].ed[p])));
            check({tag, "_last"}, cap_l[p], int'(vecs[idx].el[p]));
        end
        check({tag, "_err_odd"}, err_cnt, int'(vecs[idx].err));
    endtask

    task automatic run_row(input int idx);
        int n;
        clear_cap();
        n = int'(vecs[idx].len);
        for (int k = 0; k < n; k++) begin
            send(int'($signed(vecs[idx].x[k])), k == n - 1);
        end
        repeat (4) @(posedge clk);
        #1;
        compare_row(idx, $sformatf("row%0d", idx));
    endtask

    function automatic void set_row(input int i, input int n, input int a0, input int a1,
                                    input int a2, input int a3, input int a4, input int a5);
        vecs[i]     = '0;
        vecs[i].len = n[2:0];
        vecs[i].x[0] = a0[15:0];
        vecs[i].x[1] = a1[15:0];
        vecs[i].x[2] = a2[15:0];
        vecs[i].x[3] = a3[15:0];
        vecs[i].x[4] = a4[15:0];
        vecs[i].x[5] = a5[15:0];
    endfunction

    function automatic void set_pair(input int i, input int s, input int d, input int l);
        int p;
        p = int'(vecs[i].np);
        vecs[i].es[p] = s[17:0];
        vecs[i].ed[p] = d[17:0];
        vecs[i].el[p] = l[0];
        vecs[i].np    = vecs[i].np + 2'd1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_row(0, 4, 10, 20, 30, 40, 0, 0);
        set_pair(0, 10, 0, 0);  set_pair(0, 33, 10, 1);
        set_row(1, 2, 5, 9, 0, 0, 0, 0);
        set_pair(1, 7, 4, 1);
        set_row(2, 2, -4, -7, 0, 0, 0, 0);
        set_pair(2, -5, -3, 1);
        set_row(3, 3, 1, 2, 3, 0, 0, 0);
        set_pair(3, 1, 0, 1);   vecs[3].err = 1'b1;
        set_row(4, 4, 10, 20, 30, 40, 0, 0);
        set_pair(4, 10, 0, 0);  set_pair(4, 33, 10, 1);
        set_row(5, 1, 7, 0, 0, 0, 0, 0);
        vecs[5].err = 1'b1;
        set_row(6, 6, 1, 2, 3, 4, 5, 6);
        set_pair(6, 1, 0, 0);   set_pair(6, 3, 0, 0);   set_pair(6, 5, 1, 1);
        set_row(7, 2, 100, -100, 0, 0, 0, 0);
        set_pair(7, 0, -200, 1);
        set_row(8, 4, 32767, -32768, 32767, -32768, 0, 0);
        set_pair(8, 0, -65535, 0); set_pair(8, 0, -65535, 1);
        set_row(9, 5, 1, 2, 3, 4, 5, 0);
        set_pair(9, 1, 0, 0);   set_pair(9, 3, 0, 1);   vecs[9].err = 1'b1;

        bus.in_valid  = 1'b0;
        bus.in_data   = 16'sd0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_s", int'(bus.out_s), 0);
        check("rst_out_d", int'(bus.out_d), 0);
        check("rst_out_last", int'(bus.out_last), 0);
        check("rst_err_odd", int'(bus.err_odd), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_row(i);
        end

        // Backpressure: the first pair is held for 5 cycles, the last sample waits.
        clear_cap();
        bus.out_ready = 1'b0;
        fork
            begin
                send(10, 1'b0); send(20, 1'b0); send(30, 1'b0); send(40, 1'b1);
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (bus.out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                check("bp_pair_pending", int'(seen), 1);
                for (int c = 0; c < 5; c++) begin
                    check("bp_in_ready", int'(bus.in_ready), 0);
                    check("bp_hold_s", int'(bus.out_s), 10);
                    check("bp_hold_d", int'(bus.out_d), 0);
                    check("bp_hold_last", int'(bus.out_last), 0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        compare_row(0, "bp");

        // Reset in the middle of a row.
        clear_cap();
        send(20, 1'b0);
        send(30, 1'b0);
        check("pre_rst_s", int'(bus.out_s), 33);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", int'(bus.out_valid), 0);
        check("mid_rst_out_s", int'(bus.out_s), 0);
        check("mid_rst_out_d", int'(bus.out_d), 0);
        check("mid_rst_out_last", int'(bus.out_last), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_row(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dwt_lift53_1d.md
Name: dwt_lift53_1d

Overview:
Streaming one-level 1D LeGall 5/3 integer lifting stage. Consumes the 16-bit sample stream selected by the level input mux (raw samples or previous-level approximation) and produces one (approximation s[n], detail d[n]) coefficient pair per two input samples. Uses symmetric boundary extension at both row ends. Valid/ready handshake on both sides; the output is a single register stage.

Parameters:
DATA_W, 16, input sample width (signed two's complement)
COEF_W, DATA_W+2, output coefficient width (signed); headroom for the predict and update steps

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input sample valid
in_ready  out  1  stage accepts a sample this cycle
in_data  in  DATA_W  signed sample x[k]
in_last  in  1  marks the final sample of a row
out_valid  out  1  coefficient pair valid
out_ready  in  1  downstream accepts the pair
out_s  out  COEF_W  approximation s[n]
out_d  out  COEF_W  detail d[n]
out_last  out  1  final pair of a row
err_odd  out  1  one-cycle pulse: row had odd length

Behaviour:
- Reset values: state=S_E0, out_valid=0, out_s=0, out_d=0, out_last=0, err_odd=0, internal registers e_prev, o_prev, d_prev=0, first=1. Reset asserted mid-row discards the partial row and any pending output pair.
- Math, all signed, sign-extended to COEF_W+1 internally; floor via arithmetic right shift:
  d[n] = x[2n+1] - ((x[2n] + x[2n+2]) >>> 1)
  s[n] = x[2n] + ((d[n-1] + d[n] + 2) >>> 2)
  Boundaries: d[-1] := d[0]; x[2N] := x[2N-2].
- An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- in_ready = (state != S_TAIL) && (!out_valid || out_ready). It is deliberately uniform across states.
- FSM:
  S_E0: accept x0 -> e_prev. Go to S_ODD. If in_last is set here (row length 1), pulse err_odd, emit nothing, stay in S_E0.
  S_ODD: accept x[2n+1] -> o_prev. If in_last, go to S_TAIL; else go to S_EVEN.
  S_EVEN: accept x[2n+2]. Compute d[n] from e_prev, o_prev and in_data. Compute s[n] using d_prev, or d[n] when first=1. Register the pair with out_valid=1. Then e_prev <= in_data, d_prev <= d[n], first <= 0, go to S_ODD.
    If in_last on this sample (odd length): the pair is emitted with out_last=1, err_odd pulses, the trailing even sample is discarded, and the FSM goes to S_E0 with first=1.
  S_TAIL: accepts no input. When (!out_valid || out_ready), compute d = o_prev - e_prev and s from d_prev/first. Emit with out_last=1, set first=1, go to S_E0.
- Latency: pair n is valid on the cycle after x[2n+2] is accepted. For the last pair, it is valid on the cycle after S_TAIL is entered with the output free.
- Output hold: out_s, out_d and out_last stay stable while out_valid && !out_ready. out_valid drops after a transfer unless a new pair loads in the same cycle.
- Throughput: 1 sample/cycle sustained; S_TAIL adds one bubble per row.
- No saturation: COEF_W is sufficient for DATA_W inputs.

Decomposition:
- dwt_pkg: DATA_W / COEF_W defaults, the lift_state_t enum (S_E0, S_ODD, S_EVEN, S_TAIL), and typedefs sample_t / coef_t.
- Sub-module lift53_kernel (combinational): inputs x_even, x_odd, x_next, d_prev, use_self; outputs d, s. It is shared by S_EVEN and S_TAIL, with x_next = e_prev in the tail case.

Test Plan:
- Row 10,20,30,40 (last on 40), out_ready=1 -> (s,d)=(10,0), then (33,10) with out_last=1; err_odd never asserts.
- Row 5,9 (length 2) -> single pair (7,4) with out_last=1.
- Row -4,-7 -> (-5,-3) with out_last=1; checks floor rounding on negative values.
- Row 1,2,3 (last on 3) -> pair (1,0) with out_last=1; err_odd pulses one cycle; the next row 10,20,30,40 still yields (10,0),(33,10).
- Backpressure: hold out_ready=0 for 5 cycles during a row -> in_ready=0 after the pending pair; out_s/out_d stable; no sample lost; output matches the no-stall run.
- Assert rst for one cycle after 20,30 of a row -> outputs return to 0 immediately; the next row 5,9 yields (7,4).
